// File: rtl/ahb_sram_ctrl.sv
// AHB-lite slave for a single-port sync SRAM macro.
// Zero-wait reads/writes via a one-entry write buffer with read forwarding.
module ahb_sram_ctrl #(
  parameter int AW = 12
) (
  input  logic          HCLK,
  input  logic          HRESETn,
  input  logic          HSEL,
  input  logic [31:0]   HADDR,
  input  logic [1:0]    HTRANS,
  input  logic          HWRITE,
  input  logic [2:0]    HSIZE,
  input  logic [31:0]   HWDATA,
  input  logic          HREADY,
  output logic          HREADYOUT,
  output logic          HRESP,
  output logic [31:0]   HRDATA,
  input  logic [31:0]   SRAMRDATA,
  output logic [3:0]    SRAMWEN,
  output logic [31:0]   SRAMWDATA,
  output logic          SRAMCS0,
  output logic [AW-1:0] SRAMADDR
);

  typedef enum logic [1:0] {
    S_OKAY,
    S_ERR1,
    S_ERR2
  } state_e;

  state_e state_q, state_d;

  logic          rd_dphase_q, rd_dphase_d;
  logic [AW-1:0] rd_addr_q, rd_addr_d;
  logic          wr_dphase_q, wr_dphase_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [3:0]    wr_mask_q, wr_mask_d;
  logic          buf_valid_q, buf_valid_d;
  logic [AW-1:0] buf_addr_q, buf_addr_d;
  logic [3:0]    buf_mask_q, buf_mask_d;
  logic [31:0]   buf_data_q, buf_data_d;

  logic          valid;
  logic          illegal;
  logic [3:0]    mask;
  logic          rd_legal;
  logic          wr_legal;
  logic          err_start;
  logic          drain;
  logic [AW-1:0] haddr_w;
  logic          unused_ok;

  assign unused_ok = ^{HADDR[31:AW+2], HTRANS[0]};
  assign haddr_w   = HADDR[AW+1:2];
  assign valid     = HSEL & HTRANS[1] & HREADY;

  always_comb begin
    illegal = 1'b0;
    mask    = 4'h0;
    case (HSIZE)
      3'd0: mask = 4'b0001 << HADDR[1:0];
      3'd1: begin
        mask    = HADDR[1] ? 4'b1100 : 4'b0011;
        illegal = HADDR[0];
      end
      3'd2: begin
        mask    = 4'b1111;
        illegal = |HADDR[1:0];
      end
      default: illegal = 1'b1;
    endcase
  end

  assign rd_legal  = valid & ~illegal & ~HWRITE;
  assign wr_legal  = valid & ~illegal & HWRITE;
  assign err_start = valid & illegal;
  // reads own the SRAM port; the buffer drains on any other cycle
  assign drain     = buf_valid_q & ~rd_legal;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= S_OKAY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_OKAY:  if (err_start) state_d = S_ERR1;
      S_ERR1:  state_d = S_ERR2;
      S_ERR2:  state_d = err_start ? S_ERR1 : S_OKAY;
      default: state_d = S_OKAY;
    endcase
  end

  always_comb begin
    HREADYOUT = 1'b1;
    HRESP     = 1'b0;
    unique case (state_q)
      S_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = 1'b1;
      end
      S_ERR2:  HRESP = 1'b1;
      default: HRESP = 1'b0;
    endcase
  end

  always_comb begin
    rd_dphase_d = rd_legal;
    rd_addr_d   = rd_legal ? haddr_w : rd_addr_q;
    wr_dphase_d = wr_legal;
    wr_addr_d   = wr_legal ? haddr_w : wr_addr_q;
    wr_mask_d   = wr_legal ? mask : wr_mask_q;
    buf_valid_d = buf_valid_q;
    buf_addr_d  = buf_addr_q;
    buf_mask_d  = buf_mask_q;
    buf_data_d  = buf_data_q;
    if (drain) buf_valid_d = 1'b0;
    // a reload in the drain cycle keeps the buffer full
    if (wr_dphase_q) begin
      buf_valid_d = 1'b1;
      buf_addr_d  = wr_addr_q;
      buf_mask_d  = wr_mask_q;
      buf_data_d  = HWDATA;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      rd_dphase_q <= 1'b0;
      rd_addr_q   <= '0;
      wr_dphase_q <= 1'b0;
      wr_addr_q   <= '0;
      wr_mask_q   <= '0;
      buf_valid_q <= 1'b0;
      buf_addr_q  <= '0;
      buf_mask_q  <= '0;
      buf_data_q  <= '0;
    end else begin
      rd_dphase_q <= rd_dphase_d;
      rd_addr_q   <= rd_addr_d;
      wr_dphase_q <= wr_dphase_d;
      wr_addr_q   <= wr_addr_d;
      wr_mask_q   <= wr_mask_d;
      buf_valid_q <= buf_valid_d;
      buf_addr_q  <= buf_addr_d;
      buf_mask_q  <= buf_mask_d;
      buf_data_q  <= buf_data_d;
    end
  end

  always_comb begin
    SRAMCS0   = rd_legal | drain;
    SRAMWEN   = drain ? buf_mask_q : 4'h0;
    SRAMADDR  = rd_legal ? haddr_w : buf_addr_q;
    SRAMWDATA = buf_data_q;
  end

  always_comb begin
    HRDATA = 32'h0;
    if (rd_dphase_q) begin
      for (int i = 0; i < 4; i++) begin
        if (buf_valid_q && buf_mask_q[i] && (buf_addr_q == rd_addr_q)) begin
          HRDATA[8*i +: 8] = buf_data_q[8*i +: 8];
        end else begin
          HRDATA[8*i +: 8] = SRAMRDATA[8*i +: 8];
        end
      end
    end
  end

endmodule
